axil_ctrl_regs: RTL and testbench

AXI4-Lite slave register block sitting directly upstream of the accelerator's config/start/done port. It holds the convolution and fully-connected configuration registers and issues the one-cycle start command. It captures the 17-bit done vector into sticky W1C status bits and raises a level interrupt. The processor programs the accelerator entirely through this block; bulk data still goes over the separate BRAM port.

---
 rtl/axil_ctrl_regs.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_axil_ctrl_regs.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_ctrl_regs.sv
// AXI4-Lite register block in front of the accelerator's config/start/done port.
// Holds the conv and FC configuration, issues a one-cycle start code, and collects
// done pulses into sticky write-1-to-clear status bits that feed a level interrupt.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*       AXI4-Lite write address, data and response channels
//   s_axi_ar*/r*          AXI4-Lite read address and data channels
//   start_o               1 = SA start, 2 = FC start, one-cycle pulse, otherwise 0
//   nth_conv_o, ofmap_size_o, ifmap_ch_o, in_node_num_o, out_node_num_o
//                         configuration fields, straight from register bits
//   done_i                bit 16 = FC last, bits 15..0 = pool last
//   irq_o                 level interrupt, IRQEN[0] and any sticky status bit
//
// Write FSM:
//   state  | meaning
//   W_IDLE | waiting for awvalid and wvalid together
//   W_ACK  | awready/wready high, register commits at the end of this cycle
//   W_RESP | bvalid high until bready
//
// Read FSM:
//   state  | meaning
//   R_IDLE | waiting for arvalid
//   R_ACK  | arready high, rdata/rresp captured at the end of this cycle
//   R_DATA | rvalid high, rdata/rresp held until rready

module axil_ctrl_regs #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] ID_VALUE = 32'h5341_0001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [1:0]        start_o,
  output logic [1:0]        nth_conv_o,
  output logic [4:0]        ofmap_size_o,
  output logic [5:0]        ifmap_ch_o,
  output logic [6:0]        in_node_num_o,
  output logic [6:0]        out_node_num_o,
  input  logic [16:0]       done_i,
  output logic              irq_o
);

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_t;

  localparam logic [2:0] IDX_CTRL   = 3'd0;
  localparam logic [2:0] IDX_CONV   = 3'd1;
  localparam logic [2:0] IDX_FC     = 3'd2;
  localparam logic [2:0] IDX_STATUS = 3'd3;
  localparam logic [2:0] IDX_IRQEN  = 3'd4;
  localparam logic [2:0] IDX_ID     = 3'd5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  w_state_t    w_state_q, w_state_d;
  r_state_t    r_state_q, r_state_d;
  logic        awready_q, awready_d;
  logic        wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  start_q, start_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [1:0]  nth_conv_q, nth_conv_d;
  logic [4:0]  ofmap_size_q, ofmap_size_d;
  logic [5:0]  ifmap_ch_q, ifmap_ch_d;
  logic [6:0]  in_node_q, in_node_d;
  logic [6:0]  out_node_q, out_node_d;
  logic [16:0] status_q, status_d;
  logic        irqen_q, irqen_d;
  logic        irq_q, irq_d;

  logic [2:0]  w_idx;
  logic [2:0]  r_idx;
  logic [31:0] byte_mask;
  logic [16:0] clr_mask;
  logic [31:0] rd_val;
  logic        unused_ok;

  // Only the word index is decoded; the rest of the address and the upper
  // data bits have no meaning in this window.
  assign unused_ok = ^{s_axi_awaddr, s_axi_araddr, s_axi_wdata};

  assign w_idx     = s_axi_awaddr[4:2];
  assign r_idx     = s_axi_araddr[4:2];
  assign byte_mask = {{8{s_axi_wstrb[3]}}, {8{s_axi_wstrb[2]}},
                      {8{s_axi_wstrb[1]}}, {8{s_axi_wstrb[0]}}};

  always_comb begin
    rd_val = '0;
    case (r_idx)
      IDX_CTRL:   rd_val = {30'b0, ctrl_q};
      IDX_CONV:   rd_val = {10'b0, ifmap_ch_q, 7'b0, ofmap_size_q, 2'b0, nth_conv_q};
      IDX_FC:     rd_val = {17'b0, out_node_q, 1'b0, in_node_q};
      IDX_STATUS: rd_val = {15'b0, status_q};
      IDX_IRQEN:  rd_val = {31'b0, irqen_q};
      IDX_ID:     rd_val = ID_VALUE;
      default:    rd_val = '0;
    endcase
  end

  always_comb begin
    w_state_d    = w_state_q;
    r_state_d    = r_state_q;
    awready_d    = awready_q;
    wready_d     = wready_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    arready_d    = arready_q;
    rvalid_d     = rvalid_q;
    rresp_d      = rresp_q;
    rdata_d      = rdata_q;
    start_d      = 2'b00;
    ctrl_d       = ctrl_q;
    nth_conv_d   = nth_conv_q;
    ofmap_size_d = ofmap_size_q;
    ifmap_ch_d   = ifmap_ch_q;
    in_node_d    = in_node_q;
    out_node_d   = out_node_q;
    irqen_d      = irqen_q;
    clr_mask     = '0;

    case (w_state_q)
      W_IDLE: begin
        if (s_axi_awvalid && s_axi_wvalid) begin
          w_state_d = W_ACK;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      W_ACK: begin
        w_state_d = W_RESP;
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = 1'b1;
        bresp_d   = (w_idx <= IDX_IRQEN) ? RESP_OKAY : RESP_SLVERR;
        case (w_idx)
          IDX_CTRL: begin
            if (s_axi_wstrb[0]) begin
              ctrl_d = s_axi_wdata[1:0];
              // code 3 is reserved and must not fire either engine
              if (s_axi_wdata[1:0] == 2'd1 || s_axi_wdata[1:0] == 2'd2)
                start_d = s_axi_wdata[1:0];
            end
          end
          IDX_CONV: begin
            if (s_axi_wstrb[0]) begin
              nth_conv_d        = s_axi_wdata[1:0];
              ofmap_size_d[3:0] = s_axi_wdata[7:4];
            end
            if (s_axi_wstrb[1]) ofmap_size_d[4] = s_axi_wdata[8];
            if (s_axi_wstrb[2]) ifmap_ch_d      = s_axi_wdata[21:16];
          end
          IDX_FC: begin
            if (s_axi_wstrb[0]) in_node_d  = s_axi_wdata[6:0];
            if (s_axi_wstrb[1]) out_node_d = s_axi_wdata[14:8];
          end
          IDX_STATUS: clr_mask = s_axi_wdata[16:0] & byte_mask[16:0];
          IDX_IRQEN: begin
            if (s_axi_wstrb[0]) irqen_d = s_axi_wdata[0];
          end
          default: ;
        endcase
      end
      W_RESP: begin
        if (s_axi_bready) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase

    case (r_state_q)
      R_IDLE: begin
        if (s_axi_arvalid) begin
          r_state_d = R_ACK;
          arready_d = 1'b1;
        end
      end
      R_ACK: begin
        r_state_d = R_DATA;
        arready_d = 1'b0;
        rvalid_d  = 1'b1;
        rdata_d   = rd_val;
        rresp_d   = (r_idx <= IDX_ID) ? RESP_OKAY : RESP_SLVERR;
      end
      R_DATA: begin
        if (s_axi_rready) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase

    // a done pulse arriving with the clear of the same bit keeps it set
    status_d = (status_q & ~clr_mask) | done_i;
    irq_d    = irqen_q & (|status_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q    <= W_IDLE;
      r_state_q    <= R_IDLE;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= 2'b00;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rresp_q      <= 2'b00;
      rdata_q      <= '0;
      start_q      <= 2'b00;
      ctrl_q       <= 2'b00;
      nth_conv_q   <= '0;
      ofmap_size_q <= '0;
      ifmap_ch_q   <= '0;
      in_node_q    <= '0;
      out_node_q   <= '0;
      status_q     <= '0;
      irqen_q      <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      w_state_q    <= w_state_d;
      r_state_q    <= r_state_d;
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      arready_q    <= arready_d;
      rvalid_q     <= rvalid_d;
      rresp_q      <= rresp_d;
      rdata_q      <= rdata_d;
      start_q      <= start_d;
      ctrl_q       <= ctrl_d;
      nth_conv_q   <= nth_conv_d;
      ofmap_size_q <= ofmap_size_d;
      ifmap_ch_q   <= ifmap_ch_d;
      in_node_q    <= in_node_d;
      out_node_q   <= out_node_d;
      status_q     <= status_d;
      irqen_q      <= irqen_d;
      irq_q        <= irq_d;
    end
  end

  assign s_axi_awready  = awready_q;
  assign s_axi_wready   = wready_q;
  assign s_axi_bvalid   = bvalid_q;
  assign s_axi_bresp    = bresp_q;
  assign s_axi_arready  = arready_q;
  assign s_axi_rvalid   = rvalid_q;
  assign s_axi_rresp    = rresp_q;
  assign s_axi_rdata    = rdata_q;
  assign start_o        = start_q;
  assign nth_conv_o     = nth_conv_q;
  assign ofmap_size_o   = ofmap_size_q;
  assign ifmap_ch_o     = ifmap_ch_q;
  assign in_node_num_o  = in_node_q;
  assign out_node_num_o = out_node_q;
  assign irq_o          = irq_q;

endmodule

// File: tb/tb_axil_ctrl_regs.sv
// Directed plus randomized bench for axil_ctrl_regs. A word-level register model
// (byte-strobe merge followed by a field mask, plus a sticky status vector)
// predicts read data, responses, start pulses, config outputs and the interrupt.

module tb_axil_ctrl_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [5:0]  s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic [1:0]  start_o;
  logic [1:0]  nth_conv_o;
  logic [4:0]  ofmap_size_o;
  logic [5:0]  ifmap_ch_o;
  logic [6:0]  in_node_num_o;
  logic [6:0]  out_node_num_o;
  logic [16:0] done_i = '0;
  logic        irq_o;

  int total = 0;
  int bad = 0;

  localparam logic [31:0] ID_EXP = 32'h5341_0001;

  logic [31:0] m_reg [8];
  logic [16:0] m_status;

  axil_ctrl_regs dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .start_o(start_o),
    .nth_conv_o(nth_conv_o), .ofmap_size_o(ofmap_size_o), .ifmap_ch_o(ifmap_ch_o),
    .in_node_num_o(in_node_num_o), .out_node_num_o(out_node_num_o),
    .done_i(done_i), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] fmask(input int idx);
    case (idx)
      0: return 32'h0000_0003;
      1: return 32'h003F_01F3;
      2: return 32'h0000_7F7F;
      4: return 32'h0000_0001;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] bmask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    m_status = '0;
  endtask

  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s,
                             input logic [16:0] done_ack);
    logic [31:0] bm;
    bm = bmask(s);
    if (idx == 3) begin
      m_status = (m_status & ~(d[16:0] & bm[16:0])) | done_ack;
    end else begin
      m_status = m_status | done_ack;
      if (fmask(idx) != 0) m_reg[idx] = ((m_reg[idx] & ~bm) | (d & bm)) & fmask(idx);
    end
  endtask

  function automatic logic [31:0] model_read(input int idx);
    case (idx)
      3: return {15'b0, m_status};
      5: return ID_EXP;
      6, 7: return 32'h0;
      default: return m_reg[idx];
    endcase
  endfunction

  function automatic logic [1:0] exp_start(input int idx, input logic [31:0] d, input logic [3:0] s);
    if (idx == 0 && s[0] && (d[1:0] == 2'd1 || d[1:0] == 2'd2)) return d[1:0];
    return 2'd0;
  endfunction

  task automatic check_outputs(input string tag);
    logic [31:0] cv, fc;
    cv = m_reg[1];
    fc = m_reg[2];
    chk({tag, "_nth"},   32'(nth_conv_o),     32'(cv[1:0]));
    chk({tag, "_ofmap"}, 32'(ofmap_size_o),   32'(cv[8:4]));
    chk({tag, "_ifmap"}, 32'(ifmap_ch_o),     32'(cv[21:16]));
    chk({tag, "_in"},    32'(in_node_num_o),  32'(fc[6:0]));
    chk({tag, "_out"},   32'(out_node_num_o), 32'(fc[14:8]));
    chk({tag, "_irq"},   32'(irq_o),          32'(m_reg[4][0] & (|m_status)));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_awready"}, 32'(s_axi_awready), 0);
    chk({tag, "_wready"},  32'(s_axi_wready), 0);
    chk({tag, "_bvalid"},  32'(s_axi_bvalid), 0);
    chk({tag, "_bresp"},   32'(s_axi_bresp), 0);
    chk({tag, "_arready"}, 32'(s_axi_arready), 0);
    chk({tag, "_rvalid"},  32'(s_axi_rvalid), 0);
    chk({tag, "_rresp"},   32'(s_axi_rresp), 0);
    chk({tag, "_rdata"},   s_axi_rdata, 0);
    chk({tag, "_start"},   32'(start_o), 0);
    chk({tag, "_cfg"}, {nth_conv_o, ofmap_size_o, ifmap_ch_o, in_node_num_o, out_node_num_o}, 0);
    chk({tag, "_irq"},     32'(irq_o), 0);
  endtask

  // ---------------- bus tasks ----------------
  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int hold, input logic [16:0] done_ack,
                           output logic [1:0] resp, output logic [1:0] st1, output logic [1:0] st2);
    int n;
    resp = 2'b11; st1 = 2'b11; st2 = 2'b11;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!s_axi_awready && n < 20);
    if (!s_axi_awready) begin
      chk("aw_timeout", 32'(s_axi_awready), 1);
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      return;
    end
    chk("wready_ack", 32'(s_axi_wready), 1);
    done_i = done_ack;
    @(posedge clk); #1;
    done_i = '0; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    chk("awready_one_cycle", 32'(s_axi_awready), 0);
    n = 0;
    while (!s_axi_bvalid && n < 20) begin @(posedge clk); #1; n++; end
    chk("bvalid_up", 32'(s_axi_bvalid), 1);
    if (!s_axi_bvalid) return;
    resp = s_axi_bresp;
    st1 = start_o;
    for (int i = 0; i <= hold; i++) begin
      if (i == hold) s_axi_bready = 1'b1;
      @(posedge clk); #1;
      if (i == 0) st2 = start_o;
      if (i < hold) begin
        chk("bvalid_hold", 32'(s_axi_bvalid), 1);
        chk("bresp_hold", 32'(s_axi_bresp), 32'(resp));
      end
    end
    s_axi_bready = 1'b0;
    chk("bvalid_drop", 32'(s_axi_bvalid), 0);
  endtask

  task automatic axi_read(input logic [5:0] addr, input int hold,
                          output logic [31:0] data, output logic [1:0] resp);
    int n;
    data = 32'hxxxx_xxxx; resp = 2'b11;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!s_axi_arready && n < 20);
    if (!s_axi_arready) begin
      chk("ar_timeout", 32'(s_axi_arready), 1);
      s_axi_arvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    chk("arready_one_cycle", 32'(s_axi_arready), 0);
    n = 0;
    while (!s_axi_rvalid && n < 20) begin @(posedge clk); #1; n++; end
    chk("rvalid_up", 32'(s_axi_rvalid), 1);
    if (!s_axi_rvalid) return;
    data = s_axi_rdata;
    resp = s_axi_rresp;
    for (int i = 0; i <= hold; i++) begin
      if (i == hold) s_axi_rready = 1'b1;
      @(posedge clk); #1;
      if (i < hold) begin
        chk("rvalid_hold", 32'(s_axi_rvalid), 1);
        chk("rdata_hold", s_axi_rdata, data);
        chk("rresp_hold", 32'(s_axi_rresp), 32'(resp));
      end
    end
    s_axi_rready = 1'b0;
    chk("rvalid_drop", 32'(s_axi_rvalid), 0);
  endtask

  task automatic pulse_done(input logic [16:0] v);
    done_i = v;
    @(posedge clk); #1;
    done_i = '0;
    m_status = m_status | v;
    chk("irq_after_done", 32'(irq_o), 32'(m_reg[4][0] & (|m_status)));
  endtask

  // write through model + DUT, checking response and start pulse
  task automatic do_write(input int idx, input logic [31:0] d, input logic [3:0] s,
                          input int hold, input logic [16:0] done_ack);
    logic [1:0] resp, st1, st2;
    axi_write(6'(idx * 4), d, s, hold, done_ack, resp, st1, st2);
    model_write(idx, d, s, done_ack);
    chk("bresp", 32'(resp), (idx <= 4) ? 32'd0 : 32'd2);
    chk("start_pulse", 32'(st1), 32'(exp_start(idx, d, s)));
    chk("start_clear", 32'(st2), 0);
    check_outputs("wr");
  endtask

  task automatic do_read(input int idx, input int hold);
    logic [31:0] rd;
    logic [1:0]  resp;
    axi_read(6'(idx * 4), hold, rd, resp);
    chk("rdata", rd, model_read(idx));
    chk("rresp", 32'(resp), (idx <= 5) ? 32'd0 : 32'd2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic [1:0]  resp, st1, st2;
    int n;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // CONV full write and read-back
    do_write(1, 32'h0012_0152, 4'hF, 0, '0);
    chk("conv_nth", 32'(nth_conv_o), 2);
    chk("conv_ofmap", 32'(ofmap_size_o), 21);
    chk("conv_ifmap", 32'(ifmap_ch_o), 18);
    axi_read(6'h04, 0, rd, resp);
    chk("conv_readback", rd, 32'h0012_0152);
    chk("conv_rresp", 32'(resp), 0);
    // byte-lane 0 only
    do_write(1, 32'hFFFF_FFFF, 4'b0001, 0, '0);
    chk("conv_strb_ofmap", 32'(ofmap_size_o), 31);
    chk("conv_strb_ifmap", 32'(ifmap_ch_o), 18);

    // start codes
    axi_write(6'h00, 32'h2, 4'hF, 0, '0, resp, st1, st2);
    model_write(0, 32'h2, 4'hF, '0);
    chk("ctrl2_pulse", 32'(st1), 2);
    chk("ctrl2_after", 32'(st2), 0);
    do_read(0, 0);
    axi_write(6'h00, 32'h3, 4'hF, 0, '0, resp, st1, st2);
    model_write(0, 32'h3, 4'hF, '0);
    chk("ctrl3_no_pulse", 32'(st1), 0);
    chk("ctrl3_after", 32'(st2), 0);
    axi_read(6'h00, 0, rd, resp);
    chk("ctrl3_readback", rd, 32'h3);

    // interrupt path
    do_write(4, 32'h1, 4'hF, 0, '0);
    chk("irq_before_done", 32'(irq_o), 0);
    pulse_done(17'h1_0000);
    chk("irq_fc_done", 32'(irq_o), 1);
    axi_read(6'h0C, 0, rd, resp);
    chk("status_fc", rd, 32'h0001_0000);
    do_write(3, 32'h0001_0000, 4'hF, 0, '0);
    chk("irq_cleared", 32'(irq_o), 0);
    do_read(3, 0);

    // set beats clear on the same bit
    do_write(3, 32'h0000_0008, 4'hF, 0, 17'h8);
    axi_read(6'h0C, 0, rd, resp);
    chk("status_set_wins", rd, 32'h8);
    do_write(3, 32'h0000_0008, 4'hF, 0, '0);
    do_read(3, 0);

    // unmapped / read-only, with long back-pressure
    axi_read(6'h18, 5, rd, resp);
    chk("unmapped_rresp", 32'(resp), 2);
    chk("unmapped_rdata", rd, 0);
    axi_write(6'h14, 32'hDEAD_BEEF, 4'hF, 5, '0, resp, st1, st2);
    chk("id_write_bresp", 32'(resp), 2);
    axi_read(6'h14, 0, rd, resp);
    chk("id_value", rd, ID_EXP);
    check_outputs("after_err");

    // randomized traffic against the model
    for (int t = 0; t < 60; t++) begin
      int idx;
      logic [16:0] dack;
      if ($urandom_range(0, 3) == 0) pulse_done(17'($urandom));
      idx = int'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        dack = ($urandom_range(0, 3) == 0) ? 17'($urandom) : 17'h0;
        do_write(idx, $urandom, 4'($urandom), int'($urandom_range(0, 3)), dack);
      end else begin
        do_read(idx, int'($urandom_range(0, 3)));
      end
    end

    // reset in the middle of a write response
    do_write(2, 32'h0000_2A15, 4'hF, 0, '0);
    s_axi_awaddr = 6'h04; s_axi_wdata = 32'h0003_0010; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!s_axi_bvalid && n < 20);
    chk("midwr_bvalid_up", 32'(s_axi_bvalid), 1);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all_zero("midwr_reset");
    @(posedge clk); #1;
    chk("midwr_bvalid_next", 32'(s_axi_bvalid), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_write(2, 32'h0000_2A15, 4'hF, 0, '0);
    chk("post_reset_in", 32'(in_node_num_o), 32'h15);
    chk("post_reset_out", 32'(out_node_num_o), 32'h2A);
    do_read(2, 1);
    do_read(1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
